// File: rtl/taxi_eth_stat_pkg.sv
// Shared types for the MAC statistics counter bank.
// Event index enumeration, event count and readout FSM states.
package taxi_eth_stat_pkg;

  localparam int EVT_CNT = 9;

  typedef enum logic [3:0] {
    TX_UNDERFLOW     = 4'd0,
    TX_FIFO_OVERFLOW = 4'd1,
    TX_FIFO_BAD      = 4'd2,
    TX_FIFO_GOOD     = 4'd3,
    RX_BAD_FRAME     = 4'd4,
    RX_BAD_FCS       = 4'd5,
    RX_FIFO_OVERFLOW = 4'd6,
    RX_FIFO_BAD      = 4'd7,
    RX_FIFO_GOOD     = 4'd8
  } evt_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stat_state_t;

endpackage

// File: rtl/taxi_eth_stat_cnt_ch.sv
// One channel of event counters with clear and nonzero flag.
// TAXI_ETH_STAT_CNT_SAT_EN: saturate at all-ones instead of wrapping.
module taxi_eth_stat_cnt_ch
  import taxi_eth_stat_pkg::*;
#(
  parameter int EVT_CNT = taxi_eth_stat_pkg::EVT_CNT,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EVT_CNT-1:0]       i_evt,
  input  logic                     i_clr,
  output logic [EVT_CNT*CNT_W-1:0] o_cnt,
  output logic                     o_nz
);

  localparam logic [CNT_W-1:0] MAXV = '1;

  logic [EVT_CNT-1:0][CNT_W-1:0] r_cnt;
  logic                          r_nz;

  // Count pulses; a clear keeps a pulse arriving in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      for (int e = 0; e < EVT_CNT; e++) begin
        if (i_clr) begin
          r_cnt[e] <= CNT_W'(i_evt[e]);
        end else if (i_evt[e]) begin
`ifdef TAXI_ETH_STAT_CNT_SAT_EN
          if (r_cnt[e] != MAXV)
            r_cnt[e] <= r_cnt[e] + CNT_W'(1);
`else
          r_cnt[e] <= r_cnt[e] + CNT_W'(1);
`endif
        end
      end
    end
  end

  // Nonzero flag follows the counters by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_nz <= 1'b0;
    else
      r_nz <= |r_cnt;
  end

  assign o_cnt = r_cnt;
  assign o_nz  = r_nz;

endmodule

// File: rtl/taxi_eth_mac_stat_cnt.sv
// Multi-channel MAC statistics counter bank with snapshot readout.
// TAXI_ETH_STAT_CNT_SAT_EN selects saturating counters.
module taxi_eth_mac_stat_cnt
  import taxi_eth_stat_pkg::*;
#(
  parameter int CH_CNT  = 4,
  parameter int EVT_CNT = taxi_eth_stat_pkg::EVT_CNT,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_CNT*EVT_CNT-1:0] evt_in,
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [7:0]                rd_ch,
  input  logic                      rd_clr,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CNT_W-1:0]          m_data,
  output logic [7:0]                m_evt,
  output logic                      m_last,
  output logic                      m_err,
  output logic [CH_CNT-1:0]         ch_nz
);

  localparam int CH_W = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;
  localparam int SH_W = EVT_CNT * CNT_W;
  localparam logic [8:0] CH_LIM = 9'(CH_CNT);
  localparam logic [7:0] LAST_IDX = 8'(EVT_CNT - 1);

  logic [CH_CNT-1:0][SH_W-1:0] w_cnt;
  logic [CH_CNT-1:0]           w_hit;
  logic [CH_CNT-1:0]           w_clr;
  logic [SH_W-1:0]             w_sel;
  logic                        w_acc;
  logic                        w_in_rng;
  logic [7:0]                  w_idx_nxt;

  stat_state_t     r_state;
  logic            r_rdy;
  logic            r_valid;
  logic [SH_W-1:0] r_shd;
  logic [7:0]      r_idx;
  logic            r_last;
  logic            r_err;

  assign w_acc     = rd_valid & r_rdy;
  assign w_in_rng  = ({1'b0, rd_ch} < CH_LIM);
  assign w_idx_nxt = r_idx + 8'd1;

  for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
    assign w_hit[c] = w_in_rng &&
                      (rd_ch[CH_W-1:0] == CH_W'(c));
    assign w_clr[c] = w_acc & rd_clr & w_hit[c];

    taxi_eth_stat_cnt_ch #(
      .EVT_CNT (EVT_CNT),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .i_evt (evt_in[c*EVT_CNT +: EVT_CNT]),
      .i_clr (w_clr[c]),
      .o_cnt (w_cnt[c]),
      .o_nz  (ch_nz[c])
    );
  end

  // Select the requested channel's counters for the snapshot
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < CH_CNT; c++)
      if (w_hit[c])
        w_sel = w_cnt[c];
  end

  // Readout FSM: snapshot on accept, shift one counter per beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rdy   <= 1'b1;
      r_valid <= 1'b0;
      r_shd   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_state <= SEND;
            r_rdy   <= 1'b0;
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_shd   <= w_in_rng ? w_sel : '0;
            r_last  <= w_in_rng ? (EVT_CNT == 1) : 1'b1;
            r_err   <= ~w_in_rng;
          end
        end
        SEND: begin
          if (r_valid && m_ready) begin
            if (r_last) begin
              r_state <= IDLE;
              r_rdy   <= 1'b1;
              r_valid <= 1'b0;
              r_shd   <= '0;
              r_idx   <= '0;
              r_last  <= 1'b0;
              r_err   <= 1'b0;
            end else begin
              r_idx  <= w_idx_nxt;
              r_last <= (w_idx_nxt == LAST_IDX);
              r_shd  <= r_shd >> CNT_W;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_ready = r_rdy;
  assign m_valid  = r_valid;
  assign m_data   = r_shd[CNT_W-1:0];
  assign m_evt    = r_idx;
  assign m_last   = r_last;
  assign m_err    = r_err;

endmodule

// File: tb/tb_taxi_eth_mac_stat_cnt.sv
// Directed scoreboard bench for taxi_eth_mac_stat_cnt.
// Counter model predicts each readout beat; beats are queued and popped.
module tb_taxi_eth_mac_stat_cnt;

  localparam int CH  = 4;
  localparam int EV  = 9;
  localparam int CW  = 8;
  localparam int MAXV = (1 << CW) - 1;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] e;
    logic       l;
    logic       er;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*EV-1:0] evt_in;
  logic            rd_valid;
  logic            rd_ready;
  logic [7:0]      rd_ch;
  logic            rd_clr;
  logic            m_valid;
  logic            m_ready;
  logic [CW-1:0]   m_data;
  logic [7:0]      m_evt;
  logic            m_last;
  logic            m_err;
  logic [CH-1:0]   ch_nz;

  int    checks = 0;
  int    errors = 0;
  int    mdl [CH][EV];
  beat_t q [$];

  taxi_eth_mac_stat_cnt #(
    .CH_CNT  (CH),
    .EVT_CNT (EV),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .evt_in   (evt_in),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_ch    (rd_ch),
    .rd_clr   (rd_clr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_evt    (m_evt),
    .m_last   (m_last),
    .m_err    (m_err),
    .ch_nz    (ch_nz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int inc(input int v);
`ifdef TAXI_ETH_STAT_CNT_SAT_EN
    return (v == MAXV) ? MAXV : v + 1;
`else
    return (v + 1) & MAXV;
`endif
  endfunction

  function automatic logic [CH-1:0] nz_exp();
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++)
      for (int e = 0; e < EV; e++)
        if (mdl[c][e] != 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic mdl_zero();
    for (int c = 0; c < CH; c++)
      for (int e = 0; e < EV; e++)
        mdl[c][e] = 0;
  endtask

  task automatic pulse_n(input int c, input int e,
                         input int n);
    for (int i = 0; i < n; i++) begin
      evt_in[c*EV+e] = 1'b1;
      mdl[c][e] = inc(mdl[c][e]);
      @(posedge clk); #1;
    end
    evt_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic req(input int c, input bit clr,
                     input bit pl, input int pc,
                     input int pe);
    beat_t b;
    chk("req_ready", rd_ready, 1'b1);
    if (c < CH) begin
      for (int e = 0; e < EV; e++) begin
        b.d  = 8'(mdl[c][e]);
        b.e  = 8'(e);
        b.l  = (e == EV - 1);
        b.er = 1'b0;
        q.push_back(b);
      end
    end else begin
      b = '{d: 8'd0, e: 8'd0, l: 1'b1, er: 1'b1};
      q.push_back(b);
    end
    if (clr && c < CH)
      for (int e = 0; e < EV; e++) mdl[c][e] = 0;
    if (pl) begin
      if (clr && c < CH && pc == c)
        mdl[pc][pe] = 1;
      else
        mdl[pc][pe] = inc(mdl[pc][pe]);
      evt_in[pc*EV+pe] = 1'b1;
    end
    rd_valid = 1'b1;
    rd_ch    = 8'(c);
    rd_clr   = clr;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    rd_clr   = 1'b0;
    evt_in   = '0;
    chk("latency_valid", m_valid, 1'b1);
    chk("busy_ready", rd_ready, 1'b0);
  endtask

  task automatic drain(input int stall, input int abort);
    beat_t b;
    int    n = 0;
    int    budget = 200;
    bit    ab = 1'b0;
    logic [7:0] sd, se;
    while (q.size() > 0 && budget > 0 && !ab) begin
      if (m_valid) begin
        if (n == abort) begin
          #2 rst = 1'b1;
          #1;
          chk("rst_mvalid", m_valid, 1'b0);
          q.delete();
          mdl_zero();
          ab = 1'b1;
        end else begin
          if (n == stall) begin
            m_ready = 1'b0;
            sd = m_data;
            se = m_evt;
            repeat (10) begin
              evt_in[1*EV+0] = 1'b1;
              mdl[1][0] = inc(mdl[1][0]);
              @(posedge clk); #1;
              chk("stall_valid", m_valid, 1'b1);
              chk("stall_data", m_data, sd);
              chk("stall_evt", m_evt, se);
            end
            evt_in  = '0;
            m_ready = 1'b1;
          end
          b = q.pop_front();
          chk($sformatf("beat%0d_data", n), m_data, b.d);
          chk($sformatf("beat%0d_evt", n), m_evt, b.e);
          chk($sformatf("beat%0d_last", n), m_last, b.l);
          chk($sformatf("beat%0d_err", n), m_err, b.er);
          n++;
        end
      end
      if (!ab) begin
        @(posedge clk); #1;
        budget--;
      end
    end
    if (!ab) begin
      chk("drain_done", q.size(), 0);
      chk("end_valid", m_valid, 1'b0);
      chk("end_ready", rd_ready, 1'b1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    evt_in   = '0;
    rd_valid = 1'b0;
    rd_ch    = '0;
    rd_clr   = 1'b0;
    m_ready  = 1'b1;
    mdl_zero();
    idle(2);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_ready", rd_ready, 1'b1);
    chk("rst_nz", ch_nz, 4'b0);
    chk("rst_data", m_data, 8'd0);
    chk("rst_evt", m_evt, 8'd0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_err", m_err, 1'b0);
    rst = 1'b0;
    idle(1);

    pulse_n(2, 5, 3);
    idle(2);
    chk("nz_t1", ch_nz, nz_exp());
    chk("nz_t1_const", ch_nz, 4'b0100);
    req(2, 1'b0, 1'b0, 0, 0);
    drain(-1, -1);

    req(2, 1'b1, 1'b1, 2, 5);
    drain(-1, -1);
    req(2, 1'b0, 1'b0, 0, 0);
    drain(-1, -1);

    req(7, 1'b0, 1'b0, 0, 0);
    drain(-1, -1);
    idle(2);
    chk("nz_t3", ch_nz, nz_exp());
    req(2, 1'b0, 1'b0, 0, 0);
    drain(-1, -1);

    pulse_n(2, 1, 2);
    req(2, 1'b0, 1'b0, 0, 0);
    drain(3, -1);
    idle(2);
    chk("nz_t4", ch_nz, nz_exp());
    req(1, 1'b0, 1'b0, 0, 0);
    drain(-1, -1);

    pulse_n(0, 0, 257);
`ifdef TAXI_ETH_STAT_CNT_SAT_EN
    chk("wrap_model", mdl[0][0], 255);
`else
    chk("wrap_model", mdl[0][0], 1);
`endif
    req(0, 1'b0, 1'b0, 0, 0);
    drain(-1, -1);

    pulse_n(0, 3, 2);
    req(0, 1'b0, 1'b0, 0, 0);
    drain(-1, 4);
    @(posedge clk); #1;
    chk("inrst_ready", rd_ready, 1'b1);
    rst = 1'b0;
    idle(2);
    chk("post_rst_ready", rd_ready, 1'b1);
    chk("post_rst_valid", m_valid, 1'b0);
    chk("post_rst_nz", ch_nz, 4'b0);
    req(0, 1'b0, 1'b0, 0, 0);
    drain(-1, -1);
    req(2, 1'b0, 1'b0, 0, 0);
    drain(-1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
